// File: rtl/rld_pkg.sv
// Shared definitions for the run-length decoder: FSM states, pair field
// offsets inside a compressed word, and the byte-lane merge helper.
package rld_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_REQ  = 3'd1,
      ST_RD_WAIT = 3'd2,
      ST_EXPAND  = 3'd3,
      ST_WRITE   = 3'd4,
      ST_FLUSH   = 3'd5,
      ST_FINISH  = 3'd6
   } rld_state_t;

   localparam int unsigned COUNT_LSB   = 0;
   localparam int unsigned BYTE_LSB    = 8;
   localparam int unsigned PAIR_STRIDE = 16;
   localparam logic [31:0] BYTES_PER_WORD = 32'd4;

   // Replace one byte lane of a little-endian word.
   function automatic logic [31:0] pack_merge(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  data);
      logic [31:0] w_res;
      w_res = word;
      w_res[{lane, 3'b000} +: 8] = data;
      return w_res;
   endfunction

endpackage

// File: rtl/rld_byte_packer.sv
// Accumulates decoded bytes little-endian into a 32-bit word; lanes not yet
// written read as zero, so a partial word is already zero-padded.
module rld_byte_packer
   import rld_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        full,
   output logic [1:0]  byte_cnt
);

   logic [31:0] r_word;
   logic [1:0]  r_cnt;
   logic        r_full;

   // Lane accumulation; the count wraps to 0 as the fourth byte lands.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_word <= 32'd0;
         r_cnt  <= 2'd0;
         r_full <= 1'b0;
      end else if (clear) begin
         r_word <= 32'd0;
         r_cnt  <= 2'd0;
         r_full <= 1'b0;
      end else if (byte_valid) begin
         r_word <= pack_merge(r_word, r_cnt, byte_in);
         r_cnt  <= r_cnt + 2'd1;
         r_full <= (r_cnt == 2'd3);
      end else begin
         r_word <= r_word;
         r_cnt  <= r_cnt;
         r_full <= r_full;
      end
   end

   assign word     = r_word;
   assign full     = r_full;
   assign byte_cnt = r_cnt;

endmodule

// File: rtl/rld_decoder.sv
// Run-length decoder: reads (byte, count) pairs over SRAM port A, expands the
// runs and writes packed plaintext back. Optional macro: RLD_BOUND_CHECK_EN.
module rld_decoder
   import rld_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int RUN_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [31:0]       rle_addr,
   input  logic [31:0]       rle_size,
   input  logic [31:0]       out_addr,
   output logic [31:0]       out_size,
   output logic              done,
   output logic              port_A_clk,
   output logic [ADDR_W-1:0] port_A_addr,
   output logic [31:0]       port_A_data_in,
   input  logic [31:0]       port_A_data_out,
   output logic              port_A_we
`ifdef RLD_BOUND_CHECK_EN
   ,
   input  logic [31:0]       out_limit,
   output logic              overflow
`endif
);

   localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
   localparam logic [RUN_W-1:0] RUN_ZERO = RUN_W'(0);

   rld_state_t         r_state;
   logic [31:0]        r_rd_ptr;
   logic [31:0]        r_wr_ptr;
   logic [31:0]        r_pairs_left;
   logic [31-BYTE_LSB:0] r_word_hi;
   logic               r_pair_sel;
   logic [RUN_W-1:0]   r_remain;
   logic               r_word_done;
   logic               r_all_done;
   logic               r_done;
   logic [31:0]        r_out_size;
   logic               r_we;
   logic [ADDR_W-1:0]  r_addr;
   logic [31:0]        r_din;

   logic [31:0]        w_pack_word;
   logic               w_pack_full;
   logic [1:0]         w_pack_cnt;
   logic [7:0]         w_cur_byte;
   logic               w_bound_hit;
   logic               w_emit;
   logic               w_fill;
   logic               w_pair_end;
   logic               w_last_pair;
   logic [31:0]        w_next_word;
   logic [1:0]         w_next_cnt;
   logic               w_clear;
   rld_state_t         w_exp_next;
   logic               w_exp_we;

`ifdef RLD_BOUND_CHECK_EN
   logic r_overflow;
   assign w_bound_hit = (r_state == ST_EXPAND) && (r_remain != RUN_ZERO) &&
                        (r_out_size >= out_limit);
   assign overflow    = r_overflow;
`else
   assign w_bound_hit = 1'b0;
`endif

   // Datapath decode for the pair currently being expanded.
   always_comb begin
      if (r_pair_sel) begin
         w_cur_byte = r_word_hi[BYTE_LSB + PAIR_STRIDE - BYTE_LSB +: 8];
      end else begin
         w_cur_byte = r_word_hi[0 +: 8];
      end
      w_emit      = (r_state == ST_EXPAND) && (r_remain != RUN_ZERO) && !w_bound_hit;
      w_fill      = w_emit && (w_pack_cnt == 2'd3);
      w_pair_end  = (r_state == ST_EXPAND) && (r_remain <= RUN_ONE) && !w_bound_hit;
      w_last_pair = (r_pairs_left == 32'd1);
      w_clear     = ((r_state == ST_IDLE) && start) || (r_state == ST_WRITE);
      if (w_emit) begin
         w_next_word = pack_merge(w_pack_word, w_pack_cnt, w_cur_byte);
         w_next_cnt  = w_pack_cnt + 2'd1;
      end else begin
         w_next_word = w_pack_word;
         w_next_cnt  = w_pack_cnt;
      end
   end

   // Successor of EXPAND; a fill takes priority so the pair position survives the write.
   always_comb begin
      w_exp_next = ST_EXPAND;
      if (w_bound_hit) begin
         w_exp_next = ST_FLUSH;
      end else if (w_fill) begin
         w_exp_next = ST_WRITE;
      end else if (w_pair_end) begin
         if (w_last_pair) begin
            w_exp_next = ST_FLUSH;
         end else if (r_pair_sel) begin
            w_exp_next = ST_RD_REQ;
         end else begin
            w_exp_next = ST_EXPAND;
         end
      end else begin
         w_exp_next = ST_EXPAND;
      end
      w_exp_we = (w_exp_next == ST_WRITE) ||
                 ((w_exp_next == ST_FLUSH) && (w_next_cnt != 2'd0));
   end

   rld_byte_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (w_clear),
      .byte_valid (w_emit),
      .byte_in    (w_cur_byte),
      .word       (w_pack_word),
      .full       (w_pack_full),
      .byte_cnt   (w_pack_cnt)
   );

   // Main FSM; port A outputs are registered on entry to the state that uses them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_rd_ptr     <= 32'd0;
         r_wr_ptr     <= 32'd0;
         r_pairs_left <= 32'd0;
         r_word_hi    <= '0;
         r_pair_sel   <= 1'b0;
         r_remain     <= RUN_ZERO;
         r_word_done  <= 1'b0;
         r_all_done   <= 1'b0;
         r_done       <= 1'b0;
         r_out_size   <= 32'd0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_din        <= 32'd0;
`ifdef RLD_BOUND_CHECK_EN
         r_overflow   <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_we <= 1'b0;
               if (start) begin
                  r_done       <= 1'b0;
                  r_out_size   <= 32'd0;
                  r_rd_ptr     <= rle_addr;
                  r_wr_ptr     <= out_addr;
                  r_pairs_left <= rle_size >> 1;
                  r_word_done  <= 1'b0;
                  r_all_done   <= 1'b0;
                  r_addr       <= rle_addr[ADDR_W-1:0];
`ifdef RLD_BOUND_CHECK_EN
                  r_overflow   <= 1'b0;
`endif
                  if ((rle_size >> 1) == 32'd0) begin
                     r_state <= ST_FINISH;
                  end else begin
                     r_state <= ST_RD_REQ;
                  end
               end
            end
            ST_RD_REQ: begin
               r_we    <= 1'b0;
               r_addr  <= r_rd_ptr[ADDR_W-1:0];
               r_state <= ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
               r_word_hi   <= port_A_data_out[31:BYTE_LSB];
               r_remain    <= port_A_data_out[COUNT_LSB +: RUN_W];
               r_pair_sel  <= 1'b0;
               r_word_done <= 1'b0;
               r_rd_ptr    <= r_rd_ptr + BYTES_PER_WORD;
               r_state     <= ST_EXPAND;
            end
            ST_EXPAND: begin
               r_state <= w_exp_next;
               r_we    <= w_exp_we;
               r_din   <= w_next_word;
               r_addr  <= w_exp_we ? r_wr_ptr[ADDR_W-1:0] : r_rd_ptr[ADDR_W-1:0];
               if (w_emit) begin
                  r_out_size <= r_out_size + 32'd1;
                  r_remain   <= r_remain - RUN_ONE;
               end
`ifdef RLD_BOUND_CHECK_EN
               if (w_bound_hit) begin
                  r_overflow <= 1'b1;
               end
`endif
               if (w_pair_end) begin
                  r_pairs_left <= r_pairs_left - 32'd1;
                  if (w_last_pair) begin
                     r_all_done <= 1'b1;
                  end else if (r_pair_sel) begin
                     r_word_done <= 1'b1;
                  end else begin
                     r_pair_sel <= 1'b1;
                     r_remain   <= r_word_hi[COUNT_LSB + PAIR_STRIDE - BYTE_LSB +: RUN_W];
                  end
               end
            end
            ST_WRITE: begin
               r_we   <= 1'b0;
               r_addr <= r_rd_ptr[ADDR_W-1:0];
               if (w_pack_full) begin
                  r_wr_ptr <= r_wr_ptr + BYTES_PER_WORD;
               end
               if (r_all_done) begin
                  r_state <= ST_FLUSH;
               end else if (r_word_done) begin
                  r_state <= ST_RD_REQ;
               end else begin
                  r_state <= ST_EXPAND;
               end
            end
            ST_FLUSH: begin
               if (r_we) begin
                  r_wr_ptr <= r_wr_ptr + BYTES_PER_WORD;
               end
               r_we    <= 1'b0;
               r_addr  <= r_rd_ptr[ADDR_W-1:0];
               r_state <= ST_FINISH;
            end
            ST_FINISH: begin
               r_done  <= 1'b1;
               r_we    <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_we    <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign port_A_clk     = clk;
   assign port_A_addr    = r_addr;
   assign port_A_data_in = r_din;
   assign port_A_we      = r_we;
   assign out_size       = r_out_size;
   assign done           = r_done;

endmodule

// File: tb/tb_rld_decoder.sv
// Scoreboard bench for rld_decoder: expected SRAM writes are queued per case
// and a negedge monitor checks every write strobe against the queue head.
module tb_rld_decoder;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] rle_addr;
   logic [31:0] rle_size;
   logic [31:0] out_addr;
   logic [31:0] out_size;
   logic        done;
   logic        port_A_clk;
   logic [15:0] port_A_addr;
   logic [31:0] port_A_data_in;
   logic [31:0] port_A_data_out;
   logic        port_A_we;
`ifdef RLD_BOUND_CHECK_EN
   logic [31:0] out_limit;
   logic        overflow;
`endif

   int n_cmp = 0;
   int n_err = 0;
   logic [47:0] exp_q[$];
   logic [47:0] mon_e;

   logic [31:0] mem [0:1023];
   logic [31:0] rd_q;
   logic        ld_en;
   logic [9:0]  ld_idx;
   logic [31:0] ld_dat;

   rld_decoder #(.ADDR_W(16), .RUN_W(8)) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .rle_addr        (rle_addr),
      .rle_size        (rle_size),
      .out_addr        (out_addr),
      .out_size        (out_size),
      .done            (done),
      .port_A_clk      (port_A_clk),
      .port_A_addr     (port_A_addr),
      .port_A_data_in  (port_A_data_in),
      .port_A_data_out (port_A_data_out),
      .port_A_we       (port_A_we)
`ifdef RLD_BOUND_CHECK_EN
      ,
      .out_limit       (out_limit),
      .overflow        (overflow)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model with one-cycle read latency and a bench load port.
   always @(posedge port_A_clk) begin
      if (ld_en) mem[ld_idx] <= ld_dat;
      else if (port_A_we) mem[port_A_addr[11:2]] <= port_A_data_in;
      rd_q <= mem[port_A_addr[11:2]];
   end
   assign port_A_data_out = rd_q;

   // Monitor: pop and compare on every write strobe.
   always @(negedge clk) begin
      if (!reset && port_A_we) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL write_unexpected: got addr %h data %h, required no write",
                     port_A_addr, port_A_data_in);
         end else begin
            mon_e = exp_q.pop_front();
            if ({port_A_addr, port_A_data_in} !== mon_e) begin
               n_err++;
               $display("FAIL write_data: got addr %h data %h, required addr %h data %h",
                        port_A_addr, port_A_data_in, mon_e[47:32], mon_e[31:0]);
            end
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   task automatic push(input logic [15:0] a, input logic [31:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic mem_load(input logic [9:0] idx, input logic [31:0] d);
      @(negedge clk);
      ld_en = 1'b1; ld_idx = idx; ld_dat = d;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   task automatic run_case(input string nm, input logic [31:0] ra, input logic [31:0] rs,
                           input logic [31:0] oa, input logic [31:0] exp_size,
                           input int budget, input int max_lat);
      int cyc;
      logic seen;
      @(negedge clk);
      rle_addr = ra; rle_size = rs; out_addr = oa; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({nm, "_done_cleared"}, {31'd0, done}, 32'd0);
      cyc  = 1;
      seen = done;
      while (!seen && cyc < budget) begin
         @(negedge clk);
         cyc++;
         seen = done;
      end
      check({nm, "_done_seen"}, {31'd0, seen}, 32'd1);
      if (max_lat > 0)
         check($sformatf("%s_latency_%0d", nm, cyc), {31'd0, (cyc <= max_lat)}, 32'd1);
      check({nm, "_out_size"}, out_size, exp_size);
      check({nm, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      check({nm, "_done_held"}, {31'd0, done}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; rle_addr = 32'd0; rle_size = 32'd0; out_addr = 32'd0;
      ld_en = 1'b0; ld_idx = 10'd0; ld_dat = 32'd0;
`ifdef RLD_BOUND_CHECK_EN
      out_limit = 32'hFFFF_FFFF;
`endif
      repeat (3) @(negedge clk);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_out_size", out_size, 32'd0);
      check("rst_we", {31'd0, port_A_we}, 32'd0);
      check("rst_addr", {16'd0, port_A_addr}, 32'd0);
      check("rst_data_in", port_A_data_in, 32'd0);
      reset = 1'b0;

      // One pair, upper pair of the word ignored.
      mem_load(10'h040, 32'h0000_4103);
      push(16'h0200, 32'h0041_4141);
      run_case("c1", 32'h100, 32'd2, 32'h200, 32'd3, 50, 0);
`ifdef RLD_BOUND_CHECK_EN
      check("c1_overflow", {31'd0, overflow}, 32'd0);
`endif

      // Odd size: LSB ignored, same result.
      push(16'h0200, 32'h0041_4141);
      run_case("c1_odd", 32'h100, 32'd3, 32'h200, 32'd3, 50, 0);

      // Two pairs spanning a word boundary on output.
      mem_load(10'h040, 32'h4202_4103);
      push(16'h0200, 32'h4241_4141);
      push(16'h0204, 32'h0000_0042);
      run_case("c2", 32'h100, 32'd4, 32'h200, 32'd5, 50, 0);

      // Maximum run of 255 bytes.
      mem_load(10'h040, 32'h0000_FFFF);
      for (int i = 0; i < 63; i++) push(16'h0200 + 16'(4 * i), 32'hFFFF_FFFF);
      push(16'h02FC, 32'h00FF_FFFF);
      run_case("c3", 32'h100, 32'd2, 32'h200, 32'd255, 600, 0);

      // Empty frame.
      run_case("c4", 32'h100, 32'd0, 32'h200, 32'd0, 10, 3);

      // Padding pair in the middle, garbage upper pair of the last word.
      mem_load(10'h040, 32'h0000_4102);
      mem_load(10'h041, 32'h9999_4303);
      push(16'h0200, 32'h4343_4141);
      push(16'h0204, 32'h0000_0043);
      run_case("c5", 32'h100, 32'd6, 32'h200, 32'd5, 80, 0);

      // Asynchronous abort mid-expansion, then a clean rerun of case 2.
      mem_load(10'h040, 32'h4202_4103);
      @(negedge clk);
      rle_addr = 32'h100; rle_size = 32'd4; out_addr = 32'h200; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_busy_out_size", out_size, 32'd1);
      reset = 1'b1;
      #1;
      check("abort_we", {31'd0, port_A_we}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_out_size", out_size, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      push(16'h0200, 32'h4241_4141);
      push(16'h0204, 32'h0000_0042);
      run_case("c6_rerun", 32'h100, 32'd4, 32'h200, 32'd5, 50, 0);

`ifdef RLD_BOUND_CHECK_EN
      // Output limit truncates the 255-byte run at 10 bytes.
      mem_load(10'h040, 32'h0000_FFFF);
      out_limit = 32'd10;
      push(16'h0200, 32'hFFFF_FFFF);
      push(16'h0204, 32'hFFFF_FFFF);
      push(16'h0208, 32'h0000_FFFF);
      run_case("c7", 32'h100, 32'd2, 32'h200, 32'd10, 100, 0);
      check("c7_overflow", {31'd0, overflow}, 32'd1);
      out_limit = 32'hFFFF_FFFF;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
